reg_read_port: RTL and testbench

- Read-side companion to the 16-entry general register file.
- Accepts register read requests over a valid/ready handshake and samples the selected register output (r0outf..r15outf).
- Queues each sampled value in a small response FIFO and returns it over a second valid/ready handshake to the datapath or control-unit consumer.
- Decouples consumers from register-file timing and counts requester stall cycles.

---
 rtl/reg_read_port.sv | 124 ++++++++++++
 tb/tb_reg_read_port.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_read_port.sv
// Read-side port for the 16-entry register file: queues sampled register values in a small FIFO.
// Define REG_READ_BYPASS_EN to forward BusMuxOut when the selected register is written on accept.
module reg_read_port #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned QDEPTH = 2
) (
  input  logic                        clk,
  input  logic                        clr,
  input  logic                        rd_valid,
  output logic                        rd_ready,
  input  logic [3:0]                  rd_sel,
  input  logic [DATA_W-1:0]           r0outf,
  input  logic [DATA_W-1:0]           r1outf,
  input  logic [DATA_W-1:0]           r2outf,
  input  logic [DATA_W-1:0]           r3outf,
  input  logic [DATA_W-1:0]           r4outf,
  input  logic [DATA_W-1:0]           r5outf,
  input  logic [DATA_W-1:0]           r6outf,
  input  logic [DATA_W-1:0]           r7outf,
  input  logic [DATA_W-1:0]           r8outf,
  input  logic [DATA_W-1:0]           r9outf,
  input  logic [DATA_W-1:0]           r10outf,
  input  logic [DATA_W-1:0]           r11outf,
  input  logic [DATA_W-1:0]           r12outf,
  input  logic [DATA_W-1:0]           r13outf,
  input  logic [DATA_W-1:0]           r14outf,
  input  logic [DATA_W-1:0]           r15outf,
  input  logic [15:0]                 wr_ins,
  input  logic [DATA_W-1:0]           BusMuxOut,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [DATA_W-1:0]           rsp_data,
  output logic [3:0]                  rsp_sel,
  output logic [$clog2(QDEPTH):0]     pend_cnt,
  output logic [7:0]                  stall_cnt
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DATA_W-1:0] data_q [QDEPTH];
  logic [3:0]        sel_q  [QDEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [7:0]        stall_q, stall_d;

  logic [DATA_W-1:0] reg_vec [16];
  logic [DATA_W-1:0] push_data;
  logic              push, pop;

  always_comb begin
    reg_vec[0]  = r0outf;
    reg_vec[1]  = r1outf;
    reg_vec[2]  = r2outf;
    reg_vec[3]  = r3outf;
    reg_vec[4]  = r4outf;
    reg_vec[5]  = r5outf;
    reg_vec[6]  = r6outf;
    reg_vec[7]  = r7outf;
    reg_vec[8]  = r8outf;
    reg_vec[9]  = r9outf;
    reg_vec[10] = r10outf;
    reg_vec[11] = r11outf;
    reg_vec[12] = r12outf;
    reg_vec[13] = r13outf;
    reg_vec[14] = r14outf;
    reg_vec[15] = r15outf;
  end

`ifdef REG_READ_BYPASS_EN
  // A same-edge write wins: queue the value the register holds after this edge.
  assign push_data = wr_ins[rd_sel] ? BusMuxOut : reg_vec[rd_sel];
`else
  logic unused_wr;
  assign unused_wr = ^{wr_ins, BusMuxOut};
  assign push_data = reg_vec[rd_sel];
`endif

  assign rd_ready  = (count_q < CW'(QDEPTH));
  assign rsp_valid = (count_q != '0);
  assign rsp_data  = data_q[rd_ptr_q];
  assign rsp_sel   = sel_q[rd_ptr_q];
  assign pend_cnt  = count_q;
  assign stall_cnt = stall_q;

  assign push = rd_valid & rd_ready;
  assign pop  = rsp_valid & rsp_ready;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    stall_d  = stall_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    if (rd_valid && !rd_ready && stall_q != 8'hFF) stall_d = stall_q + 8'd1;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      stall_q  <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        data_q[i] <= '0;
        sel_q[i]  <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      stall_q  <= stall_d;
      if (push) begin
        data_q[wr_ptr_q] <= push_data;
        sel_q[wr_ptr_q]  <= rd_sel;
      end
    end
  end

endmodule

// File: tb/tb_reg_read_port.sv
// Directed self-checking bench for reg_read_port (default QDEPTH=2, DATA_W=32).
module tb_reg_read_port;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        rd_valid = 1'b0;
  logic        rd_ready;
  logic [3:0]  rd_sel = '0;
  logic [31:0] regs [16];
  logic [15:0] wr_ins = '0;
  logic [31:0] bus_mux_out = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_sel;
  logic [1:0]  pend_cnt;
  logic [7:0]  stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  reg_read_port dut (
    .clk       (clk),
    .clr       (clr),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_sel    (rd_sel),
    .r0outf    (regs[0]),
    .r1outf    (regs[1]),
    .r2outf    (regs[2]),
    .r3outf    (regs[3]),
    .r4outf    (regs[4]),
    .r5outf    (regs[5]),
    .r6outf    (regs[6]),
    .r7outf    (regs[7]),
    .r8outf    (regs[8]),
    .r9outf    (regs[9]),
    .r10outf   (regs[10]),
    .r11outf   (regs[11]),
    .r12outf   (regs[12]),
    .r13outf   (regs[13]),
    .r14outf   (regs[14]),
    .r15outf   (regs[15]),
    .wr_ins    (wr_ins),
    .BusMuxOut (bus_mux_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_sel   (rsp_sel),
    .pend_cnt  (pend_cnt),
    .stall_cnt (stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 32'h1000_0000 + i;

    // Reset with random inputs applied.
    #1 clr = 1'b0;
    rd_valid    = 1'b1;
    rsp_ready   = 1'b1;
    rd_sel      = 4'($urandom_range(0, 15));
    wr_ins      = 16'($urandom);
    bus_mux_out = $urandom;
    step();
    step();
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_pend", 32'(pend_cnt), 32'd0);
    check("rst_stall", 32'(stall_cnt), 32'd0);
    rd_valid  = 1'b0;
    rsp_ready = 1'b0;
    wr_ins    = '0;
    #2 clr = 1'b1;
    step();
    check("rst_rd_ready", 32'(rd_ready), 32'd1);
    check("rst_rsp_sel", 32'(rsp_sel), 32'd0);

    // Single read.
    regs[5]   = 32'hDEADBEEF;
    rd_sel    = 4'd5;
    rd_valid  = 1'b1;
    rsp_ready = 1'b1;
    step();
    rd_valid = 1'b0;
    check("single_valid", 32'(rsp_valid), 32'd1);
    check("single_data", rsp_data, 32'hDEADBEEF);
    check("single_sel", 32'(rsp_sel), 32'd5);
    check("single_pend", 32'(pend_cnt), 32'd1);
    step();
    check("single_drain", 32'(rsp_valid), 32'd0);

    // Fill and stall.
    rsp_ready = 1'b0;
    regs[1] = 32'd1;
    regs[2] = 32'd2;
    regs[3] = 32'd3;
    rd_valid = 1'b1;
    rd_sel = 4'd1;
    step();
    rd_sel = 4'd2;
    step();
    check("full_rd_ready", 32'(rd_ready), 32'd0);
    check("full_pend", 32'(pend_cnt), 32'd2);
    rd_sel = 4'd3;
    for (int i = 0; i < 4; i++) step();
    check("stall_4", 32'(stall_cnt), 32'd4);
    check("full_head", rsp_data, 32'd1);
    rsp_ready = 1'b1;
    step();  // pop 1; no accept at this edge since it was full
    check("fill_rsp2", rsp_data, 32'd2);
    check("fill_stall5", 32'(stall_cnt), 32'd5);
    check("fill_pend1", 32'(pend_cnt), 32'd1);
    step();  // pop 2, accept 3
    rd_valid = 1'b0;
    check("fill_rsp3", rsp_data, 32'd3);
    check("fill_sel3", 32'(rsp_sel), 32'd3);
    step();
    check("fill_empty", 32'(rsp_valid), 32'd0);

    // Simultaneous push/pop at count=1 across pointer wrap.
    for (int i = 0; i < 6; i++) regs[i] = 32'hA0 + 32'(i);
    rsp_ready = 1'b1;
    rd_valid  = 1'b1;
    rd_sel    = 4'd0;
    step();  // push into empty FIFO, nothing to pop
    for (int i = 1; i < 6; i++) begin
      rd_sel = 4'(i);
      check("pp_pend", 32'(pend_cnt), 32'd1);
      check("pp_data", rsp_data, 32'hA0 + 32'(i - 1));
      check("pp_sel", 32'(rsp_sel), 32'(i - 1));
      step();
    end
    rd_valid = 1'b0;
    check("pp_last", rsp_data, 32'hA5);
    step();
    check("pp_empty", 32'(pend_cnt), 32'd0);

    // Write collision, then a write to a different register.
    rsp_ready   = 1'b0;
    regs[7]     = 32'h11;
    bus_mux_out = 32'h22;
    wr_ins      = 16'h0080;
    rd_sel      = 4'd7;
    rd_valid    = 1'b1;
    step();
    wr_ins = 16'h0008;
    step();
    rd_valid = 1'b0;
    wr_ins   = '0;
`ifdef REG_READ_BYPASS_EN
    check("collide_data", rsp_data, 32'h22);
`else
    check("collide_data", rsp_data, 32'h11);
`endif
    rsp_ready = 1'b1;
    step();
    check("other_wr_data", rsp_data, 32'h11);
    rsp_ready = 1'b0;
    rd_valid  = 1'b1;
    step();
    rd_valid = 1'b0;
    check("pre_reset_pend", 32'(pend_cnt), 32'd2);

    // Mid-operation reset between edges.
    #2 clr = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_pend", 32'(pend_cnt), 32'd0);
    check("mid_rst_data", rsp_data, 32'd0);
    #1 clr = 1'b1;
    rsp_ready = 1'b1;
    step();
    step();
    check("post_rst_valid", 32'(rsp_valid), 32'd0);
    check("post_rst_ready", 32'(rd_ready), 32'd1);

    // Stall counter saturation.
    rsp_ready = 1'b0;
    rd_valid  = 1'b1;
    for (int i = 0; i < 2 + 260; i++) step();
    check("stall_sat", 32'(stall_cnt), 32'd255);
    rd_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
